// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared helpers for the pipelined N:1 mux tree
package mux_pkg;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int levels(input int n);
    return sel_width(n);
  endfunction

  // Word count entering a given tree level (odd counts round up via zero padding).
  function automatic int words_at(input int n, input int level);
    int w;
    w = n;
    for (int i = 0; i < level; i++) w = (w + 1) / 2;
    return w;
  endfunction

  typedef struct packed {
    logic valid;
    logic err;
  } stage_flags_t;

endpackage

// File: rtl/mux2_1.sv
// rtl/mux2_1.sv - single-bit 2:1 mux leaf cell
module mux2_1 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_level.sv
// rtl/mux_level.sv - one tree level, N_WORDS words reduced to ceil(N_WORDS/2)
module mux_level #(
  parameter  int WIDTH   = 64,
  parameter  int N_WORDS = 4,
  localparam int N_OUT   = (N_WORDS + 1) / 2
) (
  input  logic [N_WORDS*WIDTH-1:0] i_words,
  input  logic                     i_sel,
  output logic [N_OUT*WIDTH-1:0]   o_words
);

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    assign w_a = i_words[2*j*WIDTH +: WIDTH];
    if (2 * j + 1 < N_WORDS) begin : g_full
      assign w_b = i_words[(2*j+1)*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_b = '0;
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      mux2_1 u_mux (
        .i_a   (w_a[b]),
        .i_b   (w_b[b]),
        .i_sel (i_sel),
        .o_y   (o_words[j*WIDTH+b])
      );
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - N_IN:1 mux tree with registered output, valid and stall
// MUX_TREE_PIPE_STAGES_EN: register after every tree level (latency LEVELS instead of 1).
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int N_IN  = 4,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [N_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  stall,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  output logic                  sel_err
);

  localparam int LEVELS = levels(N_IN);

  logic w_in_err;

  // Out-of-range selects are zeroed at the leaves so the tree itself never needs a range check.
  assign w_in_err = (int'(sel) >= N_IN);

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NW_IN  = words_at(N_IN, l);
    localparam int NW_OUT = words_at(N_IN, l + 1);
    localparam int SW_IN  = SEL_W - l;
`ifdef MUX_TREE_PIPE_STAGES_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = (l == LEVELS - 1);
`endif

    logic [NW_IN*WIDTH-1:0]  w_words_in;
    logic [SW_IN-1:0]        w_sel_in;
    stage_flags_t            w_flags_in;
    logic [NW_OUT*WIDTH-1:0] w_words_out;
    logic [NW_OUT*WIDTH-1:0] w_stage_data;
    stage_flags_t            w_stage_flags;

    if (l == 0) begin : g_src
      assign w_words_in = w_in_err ? '0 : in;
      assign w_sel_in   = sel;
      assign w_flags_in = '{valid: in_valid, err: w_in_err};
    end else begin : g_src
      assign w_words_in = g_lvl[l-1].w_stage_data;
      assign w_sel_in   = g_lvl[l-1].g_rest.w_stage_sel;
      assign w_flags_in = g_lvl[l-1].w_stage_flags;
    end

    mux_level #(.WIDTH(WIDTH), .N_WORDS(NW_IN)) u_level (
      .i_words (w_words_in),
      .i_sel   (w_sel_in[0]),
      .o_words (w_words_out)
    );

    if (REG) begin : g_reg
      logic [NW_OUT*WIDTH-1:0] r_data;
      stage_flags_t            r_flags;

      // Data only loads on valid items so a bubble leaves the last result visible.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_data  <= '0;
          r_flags <= '0;
        end else if (!stall) begin
          r_flags <= '{valid: w_flags_in.valid, err: w_flags_in.valid & w_flags_in.err};
          if (w_flags_in.valid) r_data <= w_words_out;
        end
      end

      assign w_stage_data  = r_data;
      assign w_stage_flags = r_flags;
    end else begin : g_comb
      assign w_stage_data  = w_words_out;
      assign w_stage_flags = w_flags_in;
    end

    if (l < LEVELS - 1) begin : g_rest
      logic [SW_IN-2:0] w_stage_sel;

      if (REG) begin : g_reg
        logic [SW_IN-2:0] r_sel;

        always_ff @(posedge clk) begin
          if (!reset_n) begin
            r_sel <= '0;
          end else if (!stall && w_flags_in.valid) begin
            r_sel <= w_sel_in[SW_IN-1:1];
          end
        end

        assign w_stage_sel = r_sel;
      end else begin : g_comb
        assign w_stage_sel = w_sel_in[SW_IN-1:1];
      end
    end
  end

  assign out       = g_lvl[LEVELS-1].w_stage_data;
  assign out_valid = g_lvl[LEVELS-1].w_stage_flags.valid;
  assign sel_err   = g_lvl[LEVELS-1].w_stage_flags.err;

endmodule
